// File: rtl/picorv32_mem_iface.sv
// Native memory-bus front end for the picorv32 control FSM: turns level requests into one
// valid/ready transaction, steers store lanes and extracts load lanes.
module picorv32_mem_iface #(
    parameter bit LATCHED_MEM_RDATA = 1'b0,
    parameter bit CATCH_MISALIGN    = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        trap,
    input  logic        mem_do_prefetch,
    input  logic        mem_do_rinst,
    input  logic        mem_do_rdata,
    input  logic        mem_do_wdata,
    input  logic [1:0]  mem_wordsize,
    input  logic [31:0] reg_op1,
    input  logic [31:0] reg_op2,
    input  logic [31:0] next_pc,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata_word,
    output logic [31:0] mem_rdata_raw,
    output logic        mem_done
);

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_RD     = 2'd1,
        MEM_WR     = 2'd2,
        MEM_PFDONE = 2'd3
    } mem_state_e;

    mem_state_e  mem_state_q, mem_state_d;
    logic        mem_valid_q, mem_valid_d;
    logic        mem_instr_q, mem_instr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] rdata_q, rdata_d;

    logic        xfer;
    logic        req_instr;
    logic        req_read;
    logic        instr_misalign;
    logic        data_misalign;
    logic        read_blocked;
    logic        write_blocked;
    logic [31:0] store_wdata;
    logic [3:0]  store_wstrb;
    logic [31:0] rdata_raw;

    assign xfer      = mem_valid_q && mem_ready;
    assign req_instr = mem_do_prefetch || mem_do_rinst;
    assign req_read  = req_instr || mem_do_rdata;

    // Alignment checks; byte accesses can never be misaligned.
    always_comb begin
        instr_misalign = (next_pc[1:0] != 2'b00);
        data_misalign  = 1'b0;
        case (mem_wordsize)
            2'd1:    data_misalign = reg_op1[0];
            2'd2:    data_misalign = 1'b0;
            default: data_misalign = (reg_op1[1:0] != 2'b00);
        endcase
    end

    assign read_blocked  = CATCH_MISALIGN && (req_instr ? instr_misalign : data_misalign);
    assign write_blocked = CATCH_MISALIGN && data_misalign;

    always_comb begin
        store_wdata = reg_op2;
        store_wstrb = 4'b1111;
        case (mem_wordsize)
            2'd1: begin
                store_wdata = {2{reg_op2[15:0]}};
                store_wstrb = reg_op1[1] ? 4'b1100 : 4'b0011;
            end
            2'd2: begin
                store_wdata = {4{reg_op2[7:0]}};
                store_wstrb = 4'b0001 << reg_op1[1:0];
            end
            default: begin
                store_wdata = reg_op2;
                store_wstrb = 4'b1111;
            end
        endcase
    end

    always_comb begin
        mem_state_d = mem_state_q;
        mem_valid_d = mem_valid_q;
        mem_instr_d = mem_instr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        rdata_d     = xfer ? mem_rdata : rdata_q;

        case (mem_state_q)
            MEM_IDLE: begin
                // Read-side requests win; a blocked read never falls through to a write.
                if (!trap) begin
                    if (req_read) begin
                        if (!read_blocked) begin
                            mem_valid_d = 1'b1;
                            mem_instr_d = req_instr;
                            mem_wstrb_d = 4'b0000;
                            mem_addr_d  = req_instr ? {next_pc[31:2], 2'b00}
                                                    : {reg_op1[31:2], 2'b00};
                            mem_state_d = MEM_RD;
                        end
                    end else if (mem_do_wdata && !write_blocked) begin
                        mem_valid_d = 1'b1;
                        mem_instr_d = 1'b0;
                        mem_wstrb_d = store_wstrb;
                        mem_wdata_d = store_wdata;
                        mem_addr_d  = {reg_op1[31:2], 2'b00};
                        mem_state_d = MEM_WR;
                    end
                end
            end
            MEM_RD: begin
                if (xfer) begin
                    mem_valid_d = 1'b0;
                    mem_state_d = (mem_do_rinst || mem_do_rdata) ? MEM_IDLE : MEM_PFDONE;
                end
            end
            MEM_WR: begin
                if (xfer) begin
                    mem_valid_d = 1'b0;
                    mem_wstrb_d = 4'b0000;
                    mem_state_d = MEM_IDLE;
                end
            end
            MEM_PFDONE: begin
                if (mem_do_rinst) begin
                    mem_state_d = MEM_IDLE;
                end
            end
            default: begin
                mem_state_d = MEM_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_state_q <= MEM_IDLE;
            mem_valid_q <= 1'b0;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            mem_wstrb_q <= 4'b0000;
            rdata_q     <= 32'h0;
        end else begin
            mem_state_q <= mem_state_d;
            mem_valid_q <= mem_valid_d;
            mem_instr_q <= mem_instr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            rdata_q     <= rdata_d;
        end
    end

    // Without a latching bus the word is only valid during xfer, so replay the captured copy.
    assign rdata_raw = LATCHED_MEM_RDATA ? mem_rdata : (xfer ? mem_rdata : rdata_q);

    always_comb begin
        mem_rdata_word = rdata_raw;
        case (mem_wordsize)
            2'd1: mem_rdata_word = {16'h0, reg_op1[1] ? rdata_raw[31:16] : rdata_raw[15:0]};
            2'd2: begin
                case (reg_op1[1:0])
                    2'd0:    mem_rdata_word = {24'h0, rdata_raw[7:0]};
                    2'd1:    mem_rdata_word = {24'h0, rdata_raw[15:8]};
                    2'd2:    mem_rdata_word = {24'h0, rdata_raw[23:16]};
                    default: mem_rdata_word = {24'h0, rdata_raw[31:24]};
                endcase
            end
            default: mem_rdata_word = rdata_raw;
        endcase
    end

    assign mem_done = resetn &&
                      ((xfer && (mem_state_q != MEM_IDLE) &&
                        (mem_do_rinst || mem_do_rdata || mem_do_wdata)) ||
                       ((mem_state_q == MEM_PFDONE) && mem_do_rinst));

    assign mem_valid     = mem_valid_q;
    assign mem_instr     = mem_instr_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wstrb     = mem_wstrb_q;
    assign mem_rdata_raw = rdata_raw;

    one_request_a: assert property (@(posedge clk) disable iff (!resetn)
        $onehot0({mem_do_prefetch, mem_do_rinst, mem_do_rdata, mem_do_wdata}));

endmodule
